// File: rtl/exe_stage_pkg.sv
// Shared types, bus widths and op encodings for the execute stage.
// Latency: n/a (types and a pure combinational ALU helper only).
// Backpressure: n/a.
package exe_stage_pkg;

   localparam int DS_TO_ES_BUS_WD = 153;
   localparam int ES_TO_MS_BUS_WD = 71;
   localparam int ES_FWD_BUS_WD   = 38;

   // One-hot alu_op bit positions
   localparam int ALU_OP_ADD  = 0;
   localparam int ALU_OP_SUB  = 1;
   localparam int ALU_OP_SLT  = 2;
   localparam int ALU_OP_SLTU = 3;
   localparam int ALU_OP_AND  = 4;
   localparam int ALU_OP_NOR  = 5;
   localparam int ALU_OP_OR   = 6;
   localparam int ALU_OP_XOR  = 7;
   localparam int ALU_OP_SLL  = 8;
   localparam int ALU_OP_SRL  = 9;
   localparam int ALU_OP_SRA  = 10;
   localparam int ALU_OP_LUI  = 11;

   // div_op = {valid, is_signed, want_rem}
   localparam int DIV_OP_WANT_REM = 0;
   localparam int DIV_OP_SIGNED   = 1;
   localparam int DIV_OP_VALID    = 2;

   typedef struct packed {
      logic [11:0] alu_op;
      logic [2:0]  div_op;
      logic        res_from_mem;
      logic        src1_is_pc;
      logic        src2_is_imm;
      logic        gr_we;
      logic        mem_we;
      logic [4:0]  dest;
      logic [31:0] imm;
      logic [31:0] rj_value;
      logic [31:0] rkd_value;
      logic [31:0] pc;
   } ds_to_es_t;

   typedef struct packed {
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // AND-OR mux over the one-hot op; an all-zero op yields 0.
   function automatic logic [31:0] alu_calc(input logic [11:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      logic [4:0]  sh;
      sh = b[4:0];
      r  = '0;
      r |= {32{op[ALU_OP_ADD]}}  & (a + b);
      r |= {32{op[ALU_OP_SUB]}}  & (a - b);
      r |= {32{op[ALU_OP_SLT]}}  & {31'd0, ($signed(a) < $signed(b))};
      r |= {32{op[ALU_OP_SLTU]}} & {31'd0, (a < b)};
      r |= {32{op[ALU_OP_AND]}}  & (a & b);
      r |= {32{op[ALU_OP_NOR]}}  & ~(a | b);
      r |= {32{op[ALU_OP_OR]}}   & (a | b);
      r |= {32{op[ALU_OP_XOR]}}  & (a ^ b);
      r |= {32{op[ALU_OP_SLL]}}  & (a << sh);
      r |= {32{op[ALU_OP_SRL]}}  & (a >> sh);
      r |= {32{op[ALU_OP_SRA]}}  & 32'($signed(a) >>> sh);
      r |= {32{op[ALU_OP_LUI]}}  & b;
      return r;
   endfunction

endpackage

// File: rtl/exe_stage_divider.sv
// Iterative 32-bit restoring divider with signed/unsigned support.
// Latency: 1 setup cycle (IDLE->BUSY) + 32 iterations, then result held in DONE.
// Backpressure: stays in DONE with stable outputs until i_ack.
// Ports: clk/reset (sync, active-high); i_start/i_signed/i_a/i_b start a divide
//        from IDLE; o_busy/o_done expose FSM state; o_quotient/o_remainder valid
//        in DONE; i_ack returns DONE to IDLE.
module exe_stage_divider
   import exe_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic        i_signed,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_ack,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_quotient,
   output logic [31:0] o_remainder
);

   div_state_e  r_state;
   div_state_e  w_state_nxt;
   logic [4:0]  r_cnt;
   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_dvs;
   logic [31:0] r_a;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_dbz;

   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_shift;
   logic        w_fits;
   logic [31:0] w_diff;
   logic [31:0] w_rem_nxt;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DIV_IDLE: if (i_start)          w_state_nxt = DIV_BUSY;
         DIV_BUSY: if (r_cnt == 5'd31)   w_state_nxt = DIV_DONE;
         DIV_DONE: if (i_ack)            w_state_nxt = DIV_IDLE;
         default:                        w_state_nxt = DIV_IDLE;
      endcase
   end

   // Work on magnitudes; 0x80000000 maps onto itself, which is the correct
   // unsigned magnitude, so the most-negative case needs no special handling.
   assign w_a_mag = (i_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
   assign w_b_mag = (i_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;

   // One restoring step: shift next dividend bit in, subtract if it fits.
   // When it fits, the true difference is below the divisor, so 32 bits hold it.
   assign w_shift   = {r_rem, r_quo[31]};
   assign w_fits    = (w_shift >= {1'b0, r_dvs});
   assign w_diff    = w_shift[31:0] - r_dvs;
   assign w_rem_nxt = w_fits ? w_diff : w_shift[31:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= DIV_IDLE;
         r_cnt   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dvs   <= '0;
         r_a     <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == DIV_IDLE && i_start) begin
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_dvs   <= w_b_mag;
            r_a     <= i_a;
            r_cnt   <= '0;
            r_neg_q <= i_signed & (i_a[31] ^ i_b[31]);
            r_neg_r <= i_signed & i_a[31];
            r_dbz   <= (i_b == 32'd0);
         end else if (r_state == DIV_BUSY) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[30:0], w_fits};
            r_cnt <= r_cnt + 5'd1;
         end
      end
   end

   assign o_busy = (r_state == DIV_BUSY);
   assign o_done = (r_state == DIV_DONE);

   // Divide-by-zero returns all-ones / original dividend regardless of sign mode.
   assign o_quotient  = r_dbz   ? 32'hffff_ffff :
                        r_neg_q ? (~r_quo + 32'd1) : r_quo;
   assign o_remainder = r_dbz   ? r_a :
                        r_neg_r ? (~r_rem + 32'd1) : r_rem;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, ALU, iterative divide, data-SRAM request, result mux.
// Latency: 1 cycle for ALU/memory ops; 34 cycles from presentation for divides.
// Backpressure: holds bundle/result (and divider DONE) while ms_allowin=0; no SRAM request then.
// Ports: clk/reset (sync, active-high); ds_to_es_valid/ds_to_es_bus/es_allowin from ID;
//        es_to_ms_valid/es_to_ms_bus/ms_allowin to MEM; data_sram_* request;
//        es_fwd_bus only when EXE_FWD_EN is defined.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ms_allowin,
   output logic                       es_allowin,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       data_sram_en,
   output logic [3:0]                 data_sram_we,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata
`ifdef EXE_FWD_EN
   ,
   output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus
`endif
);

   logic        r_es_valid;
   ds_to_es_t   r_ds;

   logic [31:0] w_src1;
   logic [31:0] w_src2;
   logic [31:0] w_alu_result;
   logic [31:0] w_es_result;
   logic        w_div_en;
   logic        w_div_start;
   logic        w_div_busy;
   logic        w_div_done;
   logic        w_div_ack;
   logic [31:0] w_div_q;
   logic [31:0] w_div_r;
   logic        w_es_ready_go;
   es_to_ms_t   w_es_to_ms;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_es_valid <= 1'b0;
      end else if (es_allowin) begin
         r_es_valid <= ds_to_es_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ds <= '0;
      end else if (ds_to_es_valid && es_allowin) begin
         r_ds <= ds_to_es_bus;
      end
   end

   assign w_src1       = r_ds.src1_is_pc  ? r_ds.pc  : r_ds.rj_value;
   assign w_src2       = r_ds.src2_is_imm ? r_ds.imm : r_ds.rkd_value;
   assign w_alu_result = alu_calc(r_ds.alu_op, w_src1, w_src2);

   assign w_div_en    = r_ds.div_op[DIV_OP_VALID];
   // Only kick the divider from IDLE; while DONE and stalled by MEM the same
   // instruction must not restart it.
   assign w_div_start = r_es_valid && w_div_en && !w_div_busy && !w_div_done;
   assign w_div_ack   = es_to_ms_valid && ms_allowin;

   exe_stage_divider u_div (
      .clk         (clk),
      .reset       (reset),
      .i_start     (w_div_start),
      .i_signed    (r_ds.div_op[DIV_OP_SIGNED]),
      .i_a         (w_src1),
      .i_b         (w_src2),
      .i_ack       (w_div_ack),
      .o_busy      (w_div_busy),
      .o_done      (w_div_done),
      .o_quotient  (w_div_q),
      .o_remainder (w_div_r)
   );

   assign w_es_ready_go  = !w_div_en || w_div_done;
   assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
   assign es_to_ms_valid = r_es_valid && w_es_ready_go;

   assign w_es_result = w_div_en ? (r_ds.div_op[DIV_OP_WANT_REM] ? w_div_r : w_div_q)
                                 : w_alu_result;

   assign w_es_to_ms.res_from_mem = r_ds.res_from_mem;
   assign w_es_to_ms.gr_we        = r_ds.gr_we;
   assign w_es_to_ms.dest         = r_ds.dest;
   assign w_es_to_ms.result       = w_es_result;
   assign w_es_to_ms.pc           = r_ds.pc;
   assign es_to_ms_bus            = w_es_to_ms;

   // Memory ops are always ready, so gating on ms_allowin issues exactly one
   // request: in the cycle the instruction actually moves into MEM.
   assign data_sram_en    = r_es_valid && (r_ds.res_from_mem || r_ds.mem_we) && ms_allowin;
   assign data_sram_we    = {4{r_ds.mem_we && r_es_valid}};
   assign data_sram_addr  = w_alu_result;
   assign data_sram_wdata = r_ds.rkd_value;

`ifdef EXE_FWD_EN
   // Loads and unfinished divides report not-ready so ID stalls on them.
   assign es_fwd_bus = {r_es_valid && r_ds.gr_we && !r_ds.res_from_mem && w_es_ready_go,
                        r_ds.dest, w_es_result};
`endif

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
   import exe_stage_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         ms_allowin;
   logic         es_allowin;
   logic         ds_to_es_valid;
   logic [152:0] ds_to_es_bus;
   logic         es_to_ms_valid;
   logic [70:0]  es_to_ms_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_we;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
`ifdef EXE_FWD_EN
   logic [37:0]  es_fwd_bus;
`endif

   exe_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ms_allowin      (ms_allowin),
      .es_allowin      (es_allowin),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
`ifdef EXE_FWD_EN
      ,
      .es_fwd_bus      (es_fwd_bus)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // flags = {res_from_mem, src1_is_pc, src2_is_imm, gr_we, mem_we}
   localparam logic [4:0] F_ST  = 5'b00001;
   localparam logic [4:0] F_GR  = 5'b00010;
   localparam logic [4:0] F_IMM = 5'b00100;
   localparam logic [4:0] F_PC  = 5'b01000;
   localparam logic [4:0] F_LD  = 5'b10000;

   typedef struct {
      logic [70:0] bus;
      int          cyc;
      string       name;
   } exp_bus_t;

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cyc;
      string       name;
   } exp_mem_t;

   typedef struct {
      logic [11:0] op;
      logic [4:0]  fl;
      logic [31:0] imm;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic [31:0] pc;
      logic [31:0] exp;
   } alu_vec_t;

   typedef struct {
      logic [2:0]  dv;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } div_vec_t;

   exp_bus_t q_bus[$];
   exp_mem_t q_mem[$];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic ds_to_es_t mk(input logic [11:0] alu, input logic [2:0] dv,
                                    input logic [4:0] fl, input logic [4:0] dest,
                                    input logic [31:0] imm, input logic [31:0] rj,
                                    input logic [31:0] rkd, input logic [31:0] pc);
      ds_to_es_t d;
      d.alu_op = alu;
      d.div_op = dv;
      {d.res_from_mem, d.src1_is_pc, d.src2_is_imm, d.gr_we, d.mem_we} = fl;
      d.dest      = dest;
      d.imm       = imm;
      d.rj_value  = rj;
      d.rkd_value = rkd;
      d.pc        = pc;
      return d;
   endfunction

   // Presents one bundle; lat / mem_lat < 0 means no expectation is recorded.
   task automatic issue(input ds_to_es_t b, input string name, input int lat,
                        input logic [31:0] res, input int mem_lat);
      exp_bus_t eb;
      exp_mem_t em;
      int k;
      k = 0;
      @(negedge clk);
      while (!es_allowin && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!es_allowin) check({name, "_allowin_timeout"}, 72'(es_allowin), 72'(1));
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = b;
      if (lat >= 0) begin
         eb.bus  = {b.res_from_mem, b.gr_we, b.dest, res, b.pc};
         eb.cyc  = cyc + lat;
         eb.name = name;
         q_bus.push_back(eb);
      end
      if (mem_lat >= 0) begin
         em.we    = {4{b.mem_we}};
         em.addr  = res;
         em.wdata = b.rkd_value;
         em.cyc   = cyc + mem_lat;
         em.name  = name;
         q_mem.push_back(em);
      end
      @(posedge clk);
      #1 ds_to_es_valid = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands off to MEM or issues an SRAM request.
   exp_bus_t mb;
   exp_mem_t mm;
   always @(negedge clk) begin
      if (!reset) begin
         if (es_to_ms_valid && ms_allowin) begin
            check("ms_xfer_expected", 72'(q_bus.size() != 0), 72'(1));
            if (q_bus.size() != 0) begin
               mb = q_bus.pop_front();
               check({mb.name, "_bus"},   72'(es_to_ms_bus), 72'(mb.bus));
               check({mb.name, "_cycle"}, 72'(cyc),          72'(mb.cyc));
            end
         end
         if (data_sram_en) begin
            check("sram_req_expected", 72'(q_mem.size() != 0), 72'(1));
            if (q_mem.size() != 0) begin
               mm = q_mem.pop_front();
               check({mm.name, "_sram"},       {4'd0, data_sram_we, data_sram_addr, data_sram_wdata},
                                               {4'd0, mm.we, mm.addr, mm.wdata});
               check({mm.name, "_sram_cycle"}, 72'(cyc), 72'(mm.cyc));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   alu_vec_t av[14];
   div_vec_t dvv[10];

   initial begin
      int k;
      reset          = 1'b1;
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b0;
      ds_to_es_bus   = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_allowin",  72'(es_allowin),     72'(1));
      check("rst_ms_valid", 72'(es_to_ms_valid), 72'(0));
      check("rst_sram_en",  72'(data_sram_en),   72'(0));
      check("rst_sram_we",  72'(data_sram_we),   72'(0));

      // add.w 5+7
      issue(mk(12'h001, 3'b000, F_GR, 5'd3, 32'd0, 32'd5, 32'd7, 32'h1c00_0000), "add", 1, 32'd12, -1);
      @(negedge clk);
      check("add_no_sram", 72'(data_sram_en), 72'(0));

      // st.w 0x1000+8 <- 0xdeadbeef
      issue(mk(12'h001, 3'b000, F_IMM | F_ST, 5'd0, 32'd8, 32'h1000, 32'hdead_beef, 32'h1c00_0004),
            "st", 1, 32'h1008, 1);

      // ALU op table, issued back-to-back
      av[0]  = '{12'h002, F_GR,         32'd0,          32'd5,          32'd7,          32'h1c00_0100, 32'hffff_fffe};
      av[1]  = '{12'h004, F_GR,         32'd0,          32'hffff_ffff,  32'd1,          32'h1c00_0104, 32'd1};
      av[2]  = '{12'h008, F_GR,         32'd0,          32'hffff_ffff,  32'd1,          32'h1c00_0108, 32'd0};
      av[3]  = '{12'h010, F_GR,         32'd0,          32'hf0f0_f0f0,  32'hff00_ff00,  32'h1c00_010c, 32'hf000_f000};
      av[4]  = '{12'h020, F_GR,         32'd0,          32'h0000_ffff,  32'h00ff_0000,  32'h1c00_0110, 32'hff00_0000};
      av[5]  = '{12'h040, F_GR,         32'd0,          32'h1234_0000,  32'h0000_5678,  32'h1c00_0114, 32'h1234_5678};
      av[6]  = '{12'h080, F_GR,         32'd0,          32'hffff_0000,  32'h0ff0_0ff0,  32'h1c00_0118, 32'hf00f_0ff0};
      av[7]  = '{12'h100, F_GR | F_IMM, 32'd31,         32'd1,          32'd0,          32'h1c00_011c, 32'h8000_0000};
      av[8]  = '{12'h100, F_GR,         32'd0,          32'd1,          32'h21,         32'h1c00_0120, 32'd2};
      av[9]  = '{12'h200, F_GR,         32'd0,          32'h8000_0000,  32'd4,          32'h1c00_0124, 32'h0800_0000};
      av[10] = '{12'h400, F_GR,         32'd0,          32'h8000_0000,  32'd4,          32'h1c00_0128, 32'hf800_0000};
      av[11] = '{12'h800, F_GR | F_IMM, 32'h1234_5000,  32'hffff_ffff,  32'd0,          32'h1c00_012c, 32'h1234_5000};
      av[12] = '{12'h000, F_GR,         32'd0,          32'd5,          32'd7,          32'h1c00_0130, 32'd0};
      av[13] = '{12'h001, F_GR | F_IMM | F_PC, 32'h1000, 32'd0,         32'd0,          32'h1c00_0134, 32'h1c00_1134};
      for (int i = 0; i < 14; i++) begin
         issue(mk(av[i].op, 3'b000, av[i].fl, 5'(i + 1), av[i].imm, av[i].rj, av[i].rkd, av[i].pc),
               $sformatf("alu%0d", i), 1, av[i].exp, -1);
      end

      // div.w -7/2 then mod.w -7/2
      issue(mk(12'h000, 3'b110, F_GR, 5'd7, 32'd0, 32'hffff_fff9, 32'd2, 32'h1c00_0200),
            "div_w", 34, 32'hffff_fffd, -1);
      repeat (10) @(negedge clk);
      check("div_busy_allowin",  72'(es_allowin),     72'(0));
      check("div_busy_ms_valid", 72'(es_to_ms_valid), 72'(0));
      issue(mk(12'h000, 3'b111, F_GR, 5'd8, 32'd0, 32'hffff_fff9, 32'd2, 32'h1c00_0204),
            "mod_w", 34, 32'hffff_ffff, -1);

      // Divide corner cases
      dvv[0] = '{3'b110, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000};
      dvv[1] = '{3'b111, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000};
      dvv[2] = '{3'b100, 32'd100,       32'd0,         32'hffff_ffff};
      dvv[3] = '{3'b101, 32'd100,       32'd0,         32'd100};
      dvv[4] = '{3'b111, 32'hffff_fffb, 32'd0,         32'hffff_fffb};
      dvv[5] = '{3'b110, 32'hffff_fffb, 32'd0,         32'hffff_ffff};
      dvv[6] = '{3'b100, 32'hffff_ffff, 32'd10,        32'h1999_9999};
      dvv[7] = '{3'b101, 32'hffff_ffff, 32'd10,        32'd5};
      dvv[8] = '{3'b111, 32'd7,         32'hffff_fffe, 32'd1};
      dvv[9] = '{3'b110, 32'd7,         32'hffff_fffe, 32'hffff_fffd};
      for (int i = 0; i < 10; i++) begin
         issue(mk(12'h000, dvv[i].dv, F_GR, 5'(i + 10), 32'd0, dvv[i].a, dvv[i].b, 32'h1c00_0300 + 32'(i * 4)),
               $sformatf("div%0d", i), 34, dvv[i].exp, -1);
      end

      // ld.w with MEM stalled for 3 cycles; request only when MEM frees up
      issue(mk(12'h001, 3'b000, F_LD | F_GR | F_IMM, 5'd4, 32'd4, 32'h2000, 32'h55, 32'h1c00_0400),
            "ld", 4, 32'h2004, 4);
      ms_allowin = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("ld_stall_sram_en",  72'(data_sram_en),   72'(0));
         check("ld_stall_ms_valid", 72'(es_to_ms_valid), 72'(1));
         check("ld_stall_addr",     72'(data_sram_addr), 72'(32'h2004));
      end
      @(posedge clk);
      #1 ms_allowin = 1'b1;

      // Reset at divider iteration 10
      issue(mk(12'h000, 3'b110, F_GR, 5'd9, 32'd0, 32'd100, 32'd7, 32'h1c00_0500), "div_rst", -1, 32'd0, -1);
      repeat (11) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_allowin",  72'(es_allowin),     72'(1));
      check("midrst_ms_valid", 72'(es_to_ms_valid), 72'(0));
      issue(mk(12'h001, 3'b000, F_GR, 5'd5, 32'd0, 32'd40, 32'd2, 32'h1c00_0504), "add_after_rst", 1, 32'd42, -1);
      issue(mk(12'h000, 3'b110, F_GR, 5'd6, 32'd0, 32'd100, 32'd7, 32'h1c00_0508), "div_after_rst", 34, 32'd14, -1);
      issue(mk(12'h000, 3'b111, F_GR, 5'd6, 32'd0, 32'd100, 32'd7, 32'h1c00_050c), "mod_after_rst", 34, 32'd2, -1);

      k = 0;
      while ((q_bus.size() + q_mem.size()) != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("scoreboard_drained", 72'(q_bus.size() + q_mem.size()), 72'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
